// File: rtl/clk_tick_pkg.sv
// Shared definitions for the clock-tick controller: state encoding,
// counter width and the divisor-to-terminal helper.
package clk_tick_pkg;

  localparam int CNT_W = 28;

  typedef logic [CNT_W-1:0] cnt_t;

  // Encoding is visible on the state output, so the values are fixed.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    FAST  = 2'd3
  } state_e;

  // Terminal count for a divider: the counter runs 0..(clk_freq/rate_hz)-1.
  // The divisor itself must be >= 2 and < 2**CNT_W.
  function automatic cnt_t div_term(input int clk_freq, input int rate_hz);
    return cnt_t'((clk_freq / rate_hz) - 1);
  endfunction

endpackage

// File: rtl/tick_counter.sv
// Wrapping divider counter. Counts 0..i_term while enabled, wraps to 0 at
// the terminal value and registers a one-cycle pulse on that same edge.
// i_clr forces the count to 0 and suppresses any pulse on that edge.
module tick_counter
  import clk_tick_pkg::*;
(
  input  logic clk_in,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  input  cnt_t i_term,
  output logic o_pulse
);

  cnt_t r_cnt;
  logic r_pulse;

  // Count, wrap and pulse generation; clear has priority over counting.
  // Using >= keeps the counter from running away if the terminal value
  // drops below the current count after a divisor change.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else if (i_clr) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else if (i_en) begin
      if (r_cnt >= i_term) begin
        r_cnt   <= '0;
        r_pulse <= 1'b1;
      end else begin
        r_cnt   <= r_cnt + cnt_t'(1);
        r_pulse <= 1'b0;
      end
    end else begin
      r_pulse <= 1'b0;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/clk_tick_ctrl.sv
// Clock-tick controller: a free-running display-scan divider and a
// timekeeping divider gated by a small IDLE/RUN/PAUSE/FAST state machine.
// Optional feature macro: CLK_TICK_FAST_EN enables the FAST state, in which
// timekeeping ticks at FAST_HZ while fast_req is held. Without it fast_req
// is ignored and the state output never reads 3.
module clk_tick_ctrl
  import clk_tick_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int SEC_HZ   = 1,
  parameter int FAST_HZ  = 50
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       run_req,
  input  logic       pause_req,
  input  logic       stop_req,
  input  logic       fast_req,
  output logic       tick_scan,
  output logic       tick_sec,
  output logic [1:0] state,
  output logic       running
);

  localparam cnt_t SCAN_TERM = div_term(CLK_FREQ, SCAN_HZ);
  localparam cnt_t SEC_TERM  = div_term(CLK_FREQ, SEC_HZ);

  state_e r_state;
  state_e w_next_state;
  logic   w_sec_clr;
  logic   w_sec_en;
  cnt_t   w_sec_term;

`ifdef CLK_TICK_FAST_EN
  localparam cnt_t FAST_TERM = div_term(CLK_FREQ, FAST_HZ);

  // Timekeeping divisor follows the current state.
  assign w_sec_term = (r_state == FAST) ? FAST_TERM : SEC_TERM;
`else
  localparam int unused_fast_hz = FAST_HZ;
  logic w_unused_fast;

  assign w_unused_fast = fast_req;
  assign w_sec_term    = SEC_TERM;
`endif

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and counter-clear decode. Priority is stop > pause > fast >
  // run; a request that has no meaning in the current state is ignored and
  // the next valid one in priority order is considered.
  always_comb begin
    w_next_state = r_state;
    w_sec_clr    = 1'b0;
    if (stop_req) begin
      w_next_state = IDLE;
      w_sec_clr    = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (run_req) begin
            w_next_state = RUN;
          end
        end
        RUN: begin
          if (pause_req) begin
            w_next_state = PAUSE;
`ifdef CLK_TICK_FAST_EN
          end else if (fast_req) begin
            w_next_state = FAST;
            w_sec_clr    = 1'b1;
`endif
          end
        end
        PAUSE: begin
          if (run_req) begin
            w_next_state = RUN;
          end
        end
        FAST: begin
`ifdef CLK_TICK_FAST_EN
          if (pause_req) begin
            w_next_state = PAUSE;
          end else if (!fast_req) begin
            w_next_state = RUN;
            w_sec_clr    = 1'b1;
          end
`else
          w_next_state = IDLE;
`endif
        end
        default: begin
          w_next_state = IDLE;
        end
      endcase
    end
  end

  // Timekeeping advances only while running; the enable is taken from the
  // current state, so the edge that leaves RUN/FAST still counts (and may
  // still wrap), while the edge that enters RUN does not.
  assign w_sec_en = (r_state == RUN) || (r_state == FAST);

  tick_counter u_scan_cnt (
    .clk_in  (clk_in),
    .rst     (rst),
    .i_en    (1'b1),
    .i_clr   (1'b0),
    .i_term  (SCAN_TERM),
    .o_pulse (tick_scan)
  );

  tick_counter u_sec_cnt (
    .clk_in  (clk_in),
    .rst     (rst),
    .i_en    (w_sec_en),
    .i_clr   (w_sec_clr),
    .i_term  (w_sec_term),
    .o_pulse (tick_sec)
  );

  assign state   = r_state;
  assign running = w_sec_en;

endmodule

// File: tb/tb_clk_tick_ctrl.sv
// Bench for clk_tick_ctrl with divisors 10 (scan), 1000 (sec), 20 (fast).
// A behavioural model derives expected outputs from edge counts and is
// compared with the DUT every cycle; directed sequences add hand-computed
// tick latencies. Build with or without CLK_TICK_FAST_EN.
module tb_clk_tick_ctrl;

  localparam int CLK_FREQ = 1000;
  localparam int SCAN_HZ  = 100;
  localparam int SEC_HZ   = 1;
  localparam int FAST_HZ  = 50;
  localparam int SCAN_DIV = CLK_FREQ / SCAN_HZ;
  localparam int SEC_DIV  = CLK_FREQ / SEC_HZ;
  localparam int FAST_DIV = CLK_FREQ / FAST_HZ;
`ifdef CLK_TICK_FAST_EN
  localparam bit FAST_EN = 1'b1;
`else
  localparam bit FAST_EN = 1'b0;
`endif

  logic       clk_in;
  logic       rst;
  logic       run_req;
  logic       pause_req;
  logic       stop_req;
  logic       fast_req;
  logic       tick_scan;
  logic       tick_sec;
  logic [1:0] state;
  logic       running;

  int n_chk;
  int n_err;

  // Model state: edges since reset, enabled edges since the last
  // timekeeping clear/wrap, and the expected outputs after each edge.
  bit m_valid;
  int m_state;
  int m_scan_edges;
  int m_sec_phase;
  bit e_scan;
  bit e_sec;

  clk_tick_ctrl #(
    .CLK_FREQ (CLK_FREQ),
    .SCAN_HZ  (SCAN_HZ),
    .SEC_HZ   (SEC_HZ),
    .FAST_HZ  (FAST_HZ)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .run_req   (run_req),
    .pause_req (pause_req),
    .stop_req  (stop_req),
    .fast_req  (fast_req),
    .tick_scan (tick_scan),
    .tick_sec  (tick_sec),
    .state     (state),
    .running   (running)
  );

  // Clock and reset defaults.
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 25) begin
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
    end
  endtask

  // Behavioural model, advanced once per rising edge using the inputs
  // that were applied on the preceding falling edge.
  task automatic model_step();
    int  nxt;
    bit  clr;
    int  div;
    if (rst) begin
      m_valid      = 1'b1;
      m_state      = 0;
      m_scan_edges = 0;
      m_sec_phase  = 0;
      e_scan       = 1'b0;
      e_sec        = 1'b0;
    end else begin
      // Scan: pulse after every SCAN_DIV-th edge since reset.
      m_scan_edges++;
      e_scan = ((m_scan_edges % SCAN_DIV) == 0);
      nxt = m_state;
      clr = 1'b0;
      if (stop_req) begin
        nxt = 0;
        clr = 1'b1;
      end else if (m_state == 0) begin
        if (run_req) nxt = 1;
      end else if (m_state == 1) begin
        if (pause_req) nxt = 2;
        else if (FAST_EN && fast_req) begin
          nxt = 3;
          clr = 1'b1;
        end
      end else if (m_state == 2) begin
        if (run_req) nxt = 1;
      end else begin
        if (pause_req) nxt = 2;
        else if (!fast_req) begin
          nxt = 1;
          clr = 1'b1;
        end
      end
      e_sec = 1'b0;
      if (clr) begin
        m_sec_phase = 0;
      end else if (m_state == 1 || m_state == 3) begin
        div = (m_state == 3) ? FAST_DIV : SEC_DIV;
        m_sec_phase++;
        if (m_sec_phase >= div) begin
          m_sec_phase = 0;
          e_sec       = 1'b1;
        end
      end
      m_state = nxt;
    end
  endtask

  initial begin
    m_valid = 1'b0;
    forever begin
      @(posedge clk_in);
      model_step();
    end
  end

  // Scoreboard compare on every falling edge once reset has been seen.
  initial begin
    forever begin
      @(negedge clk_in);
      if (m_valid) begin
        chk("model_tick_scan", tick_scan, e_scan);
        chk("model_tick_sec", tick_sec, e_sec);
        chk("model_state", state, m_state);
        chk("model_running", running, (m_state == 1 || m_state == 3));
      end
    end
  end

  // Apply one cycle of requests, then return them all low.
  task automatic drive_cycle(input bit r, input bit p, input bit s, input bit f);
    run_req   = r;
    pause_req = p;
    stop_req  = s;
    fast_req  = f;
    @(negedge clk_in);
    run_req   = 1'b0;
    pause_req = 1'b0;
    stop_req  = 1'b0;
    fast_req  = 1'b0;
  endtask

  // Falling edges until the selected tick is seen; -1 if the budget expires.
  task automatic wait_pulse(input bit sel_sec, input int limit, output int n);
    int k;
    bit seen;
    k    = 0;
    seen = 1'b0;
    while (!seen && k < limit) begin
      @(negedge clk_in);
      k++;
      if (sel_sec ? (tick_sec === 1'b1) : (tick_scan === 1'b1)) seen = 1'b1;
    end
    n = seen ? k : -1;
  endtask

  // Directed sequences with hand-computed latencies.
  initial begin
    int n;
    int cnt;
    n_chk     = 0;
    n_err     = 0;
    rst       = 1'b1;
    run_req   = 1'b0;
    pause_req = 1'b0;
    stop_req  = 1'b0;
    fast_req  = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk_in);
    chk("rst_state", state, 0);
    chk("rst_running", running, 0);
    chk("rst_tick_scan", tick_scan, 0);
    chk("rst_tick_sec", tick_sec, 0);

    // Idle after reset: scan every 10 cycles, counted from the last reset edge.
    rst = 1'b0;
    wait_pulse(1'b0, 30, n);
    chk("scan_first", n, 10);
    wait_pulse(1'b0, 30, n);
    chk("scan_period", n, 10);
    chk("idle_state", state, 0);

    // Start timekeeping: first tick 1000 cycles after the transition edge.
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("run_state", state, 1);
    chk("run_running", running, 1);
    wait_pulse(1'b1, 1100, n);
    chk("sec_first", n, 1000);
    wait_pulse(1'b1, 1100, n);
    chk("sec_period", n, 1000);

    // Stop and pause together: stop wins and clears the phase.
    repeat (123) @(negedge clk_in);
    drive_cycle(1'b0, 1'b1, 1'b1, 1'b0);
    chk("stop_pause_state", state, 0);
    chk("stop_pause_running", running, 0);
    repeat (5) @(negedge clk_in);
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    wait_pulse(1'b1, 1100, n);
    chk("sec_after_stop", n, 1000);

    // Pause 400 cycles into RUN, resume 300 cycles later: 600 to go.
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (399) @(negedge clk_in);
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("pause_state", state, 2);
    chk("pause_running", running, 0);
    cnt = 0;
    for (int i = 0; i < 299; i++) begin
      @(negedge clk_in);
      if (tick_sec === 1'b1) cnt++;
    end
    chk("pause_no_tick", cnt, 0);
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("resume_state", state, 1);
    wait_pulse(1'b1, 700, n);
    chk("sec_after_resume", n, 600);

    // Wrap on the same edge as a pause request still ticks.
    repeat (999) @(negedge clk_in);
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("wrap_pause_tick", tick_sec, 1);
    chk("wrap_pause_state", state, 2);
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // Fast mode.
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (50) @(negedge clk_in);
    fast_req = 1'b1;
    @(negedge clk_in);
`ifdef CLK_TICK_FAST_EN
    chk("fast_state", state, 3);
    chk("fast_running", running, 1);
    wait_pulse(1'b1, 40, n);
    chk("fast_first", n, 20);
    wait_pulse(1'b1, 40, n);
    chk("fast_period", n, 20);
    fast_req = 1'b0;
    @(negedge clk_in);
    chk("fast_exit_state", state, 1);
    wait_pulse(1'b1, 1100, n);
    chk("sec_after_fast", n, 1000);
`else
    chk("fast_ignored_state", state, 1);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_in);
      if (state === 2'd3) cnt++;
    end
    chk("fast_never_state3", cnt, 0);
    fast_req = 1'b0;
    @(negedge clk_in);
    chk("fast_ignored_after", state, 1);
`endif

    // Reset for one cycle mid-RUN.
    repeat (37) @(negedge clk_in);
    rst = 1'b1;
    @(negedge clk_in);
    chk("midrst_state", state, 0);
    chk("midrst_running", running, 0);
    chk("midrst_tick_scan", tick_scan, 0);
    chk("midrst_tick_sec", tick_sec, 0);
    rst = 1'b0;
    wait_pulse(1'b0, 30, n);
    chk("midrst_scan_first", n, 10);
    chk("midrst_idle", state, 0);

    repeat (3) @(negedge clk_in);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/clk_tick_ctrl.md
CLK_TICK_CTRL -- requirements
Module: clk_tick_ctrl

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, input clock frequency in Hz.
REQ-002 Parameter SCAN_HZ, default 1000, display-scan tick rate in Hz.
REQ-003 Parameter SEC_HZ, default 1, timekeeping tick rate in Hz.
REQ-004 Parameter FAST_HZ, default 50, timekeeping tick rate in Hz during time-set fast mode.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk_in  input  1  system clock, all logic on rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 run_req  input  1  level sampled each cycle; start or resume timekeeping.
REQ-009 pause_req  input  1  level sampled each cycle; freeze timekeeping.
REQ-010 stop_req  input  1  level sampled each cycle; stop and clear timekeeping phase.
REQ-011 fast_req  input  1  level; while high, timekeeping ticks at FAST_HZ.
REQ-012 tick_scan  output  1  one-cycle registered pulse at SCAN_HZ.
REQ-013 tick_sec  output  1  one-cycle registered pulse at SEC_HZ, or FAST_HZ in FAST.
REQ-014 state  output  2  current state: IDLE=0, RUN=1, PAUSE=2, FAST=3.
REQ-015 running  output  1  high when state is RUN or FAST.

Function
REQ-016 Divisors SHALL be SCAN_DIV=CLK_FREQ/SCAN_HZ, SEC_DIV=CLK_FREQ/SEC_HZ, FAST_DIV=CLK_FREQ/FAST_HZ; each must be >=2 and <2^28; counters are 28 bits wide.
REQ-017 The scan counter SHALL free-run in every state: it counts 0..SCAN_DIV-1 and wraps to 0.
REQ-018 On the edge where the scan counter equals SCAN_DIV-1, tick_scan SHALL be registered high for exactly the next cycle.
REQ-019 The sec counter SHALL increment only in RUN (terminal SEC_DIV-1) and in FAST (terminal FAST_DIV-1); at terminal it wraps to 0 and tick_sec pulses for one cycle.
REQ-020 The sec counter SHALL hold its value in PAUSE and be 0 in IDLE.
REQ-021 Request priority each cycle SHALL be stop_req > pause_req > fast_req > run_req.
REQ-022 From any state, stop_req SHALL go to IDLE and clear the sec counter.
REQ-023 IDLE + run_req SHALL go to RUN with the sec counter at 0; the first tick_sec is high SEC_DIV cycles after the transition edge.
REQ-024 RUN + pause_req SHALL go to PAUSE; PAUSE + run_req SHALL go to RUN, resuming from the held count.
REQ-025 RUN + fast_req SHALL go to FAST and clear the sec counter.
REQ-026 FAST + fast_req low SHALL go to RUN and clear the sec counter; FAST + pause_req SHALL go to PAUSE.
REQ-027 A transition edge SHALL NOT itself produce a tick_sec.
REQ-028 A wrap on the same edge as a pause_req SHALL still emit that tick_sec.
REQ-029 Requests that are not valid in the current state SHALL be ignored.

Reset
REQ-030 While rst is high at a clock edge, the block SHALL set: state=IDLE, both counters=0, tick_scan=0, tick_sec=0, running=0.
REQ-031 Reset asserted mid-operation SHALL discard phase; after release, the first tick_scan is high SCAN_DIV cycles after the first non-reset edge.

Configuration
REQ-032 Macro CLK_TICK_FAST_EN SHALL compile in FAST mode as specified above.
REQ-033 Without CLK_TICK_FAST_EN, fast_req SHALL be ignored, state SHALL never equal 3, and the FAST_DIV logic SHALL be absent.

Structure
REQ-034 Package clk_tick_pkg SHALL hold the state encoding constants (IDLE/RUN/PAUSE/FAST) and CNT_W=28.
REQ-035 Sub-module tick_counter (enable, clear, terminal value, pulse out) SHALL be instantiated twice, for scan and sec.
REQ-036 clk_tick_ctrl SHALL contain the state machine and divisor selection only.

Verification (CLK_FREQ=1000, SCAN_HZ=100, SEC_HZ=1, FAST_HZ=50 -> divisors 10/1000/20)
REQ-037 Reset released, no requests -> tick_scan every 10 cycles, tick_sec never, state=0, running=0.
REQ-038 run_req pulsed one cycle -> state=1; tick_sec high 1000 cycles later, then every 1000 cycles.
REQ-039 pause_req 400 cycles into RUN, run_req 300 cycles later -> no tick_sec while paused; next tick_sec 600 cycles after resume; tick_scan uninterrupted throughout.
REQ-040 fast_req held in RUN -> state=3, tick_sec every 20 cycles; fast_req dropped -> state=1, next tick_sec 1000 cycles later; macro undefined -> fast_req has no effect.
REQ-041 stop_req and pause_req in the same RUN cycle -> state=0, sec count 0; a later run_req gives the first tick_sec at +1000 cycles.
REQ-042 rst high for one cycle mid-RUN -> all outputs 0, state=0; first tick_scan 10 cycles after release.
